bram_boot_loader: RTL and testbench
===================================

Name: bram_boot_loader

Overview:
- Upstream loader for the rv32i single-core CPU.
- Consumes a byte stream (e.g. from a UART receiver) using a valid/ready handshake, and parses framed load commands.
- Drives the write ports of the instruction BRAM and the data BRAM.
- On the run command, releases the CPU by deasserting the PC stall and handing data-BRAM write control to the core.

Parameters:
- DATA_WIDTH, 32, BRAM word width in bits.
- ADDR_WIDTH, 10, BRAM byte-address width.
- MAX_WORDS, 256, maximum words per section (2**ADDR_WIDTH/4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_dat  in  8  incoming stream byte.
- s_valid  in  1  s_dat is valid.
- s_ready  out  1  loader accepts the byte this cycle.
- i_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address.
- i_w_dat  out  DATA_WIDTH  instruction BRAM write data.
- i_w_enb  out  1  instruction BRAM write enable, one-cycle pulse.
- d_w_addr  out  ADDR_WIDTH  data BRAM write byte address.
- d_w_dat  out  DATA_WIDTH  data BRAM write data.
- d_w_enb  out  1  data BRAM write enable, one-cycle pulse.
- pc_stall  out  1  high holds the PC.
- d_bram_init_done  out  1  high hands data BRAM write muxing to the core.
- busy  out  1  a section load is in progress.
- error  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - i_w_enb, d_w_enb, busy, error, d_bram_init_done = 0; pc_stall = 1.
  - All addresses and data = 0; s_ready = 0 while rst is low.
- Byte transfer occurs on any rising edge with s_valid && s_ready.
- Frame format: CMD byte.
  - For a load command: CMD, CNT_LO, CNT_HI (16-bit word count, little-endian), then CNT×4 payload bytes.
  - Each payload word is little-endian: the first byte goes to bits [7:0].
- Commands:
  - 0xA5 = instruction section.
  - 0x5A = data section.
  - 0xFF = run.
  - Any other value is an error.
- States:
  - IDLE: s_ready=1. On 0xA5/0x5A, latch the target and clear the word index, then go to CNT_LO. On 0xFF go to RUN. On any other byte go to ERR.
  - CNT_LO: s_ready=1; latch the low count byte, then go to CNT_HI.
  - CNT_HI: s_ready=1; latch the high count byte.
    - count==0 → IDLE.
    - count>MAX_WORDS → ERR.
    - otherwise → DATA with byte index 0.
  - DATA: s_ready=1; shift the byte into the assembly register. After the 4th byte go to WRITE.
  - WRITE (exactly one cycle): s_ready=0.
    - Assert the selected *_w_enb for this cycle.
    - *_w_addr = word_index×4 (truncated to ADDR_WIDTH); *_w_dat = the assembled word.
    - The non-selected port's enable stays 0.
    - Increment word_index. If word_index+1==count go to IDLE, else go to DATA.
  - RUN: s_ready=0, pc_stall=0, d_bram_init_done=1. Held until reset; all further bytes are ignored (never accepted).
  - ERR: s_ready=0, error=1, pc_stall=1. Held until reset.
- busy = 1 in CNT_LO, CNT_HI, DATA and WRITE.
- Latency: the write enable is high in the cycle after the edge that accepts the 4th payload byte.
- Addresses and data hold their last value after a write. Enables are never high for more than one cycle per word.
- Sections may repeat and in any order, each restarting at address 0. A later write to the same address overwrites the earlier one.
- s_valid gaps: any number of idle cycles between bytes is allowed; the state is held.
- Reset mid-frame aborts the frame. No partial word is written, and the state returns to IDLE with the reset values above.

Test Plan:
- Reset, then send A5 02 00 | 13 05 10 00 | 93 05 20 00.
  - Required: i_w_enb pulses twice, at addr 0x000 dat 0x00100513 and addr 0x004 dat 0x00200593.
  - d_w_enb stays 0; pc_stall stays 1.
- Send 5A 03 00 followed by words 1, 3, 5.
  - Required: d_w_enb pulses at 0x000/0x004/0x008 with data 0x1/0x3/0x5.
  - Then send FF. Required: one cycle later pc_stall=0, d_bram_init_done=1, s_ready=0.
- Send A5 00 00, then 5A 01 00 EF BE AD DE.
  - Required: no instruction write; the state returns to IDLE.
  - A single d_w_enb pulse at addr 0x000 with dat 0xDEADBEEF.
- Send A5 01 01 (count 257).
  - Required: error=1 and s_ready=0 after the CNT_HI byte; no writes.
  - Send bad CMD 0x33 after a fresh reset. Required: error=1.
- Send a data word with s_valid toggling 1,0,0,1 between bytes.
  - Required: identical write result; no spurious enable.
- Assert rst low after 2 payload bytes, then release.
  - Required: no write occurred; pc_stall=1 and busy=0.
  - A new A5 frame then loads correctly from address 0.

Source files
------------

// File: rtl/bram_boot_loader.sv
// Byte-stream boot loader for the rv32i core: parses framed load commands,
// writes instruction/data BRAM words, and releases the CPU on the run command.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   s_dat/s_valid/      incoming byte stream (valid/ready handshake)
//   s_ready
//   i_w_addr/dat/enb    instruction BRAM write port
//   d_w_addr/dat/enb    data BRAM write port
//   pc_stall            holds the PC until the run command
//   d_bram_init_done    hands data BRAM write muxing to the core
//   busy, error         section load in progress / sticky protocol error
module bram_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_dat,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  pc_stall,
    output logic                  d_bram_init_done,
    output logic                  busy,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERR
    } state_t;

    state_t                  state;
    logic                    sel_d;
    logic [15:0]             cnt;
    logic [15:0]             widx;
    logic [BW-1:0]           bidx;
    logic [DATA_WIDTH-1:0]   asm_w;

    logic                    xfer;
    logic [15:0]             cnt_nxt;
    logic [DATA_WIDTH-1:0]   word_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;

    assign s_ready = rst && (state == IDLE || state == CNT_LO ||
                             state == CNT_HI || state == DATA);
    assign xfer     = s_valid && s_ready;
    assign cnt_nxt  = {s_dat, cnt[7:0]};
    // Bytes shift in from the top so the first byte ends in [7:0].
    assign word_nxt = {s_dat, asm_w[DATA_WIDTH-1:8]};
    assign addr_nxt = ADDR_WIDTH'({widx, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            sel_d            <= 1'b0;
            cnt              <= '0;
            widx             <= '0;
            bidx             <= '0;
            asm_w            <= '0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            pc_stall         <= 1'b1;
            d_bram_init_done <= 1'b0;
            busy             <= 1'b0;
            error            <= 1'b0;
        end else begin
            i_w_enb <= 1'b0;
            d_w_enb <= 1'b0;
            unique case (state)
                IDLE: if (xfer) begin
                    case (s_dat)
                        8'hA5, 8'h5A: begin
                            sel_d <= (s_dat == 8'h5A);
                            widx  <= '0;
                            busy  <= 1'b1;
                            state <= CNT_LO;
                        end
                        8'hFF: begin
                            pc_stall         <= 1'b0;
                            d_bram_init_done <= 1'b1;
                            state            <= RUN;
                        end
                        default: begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    endcase
                end
                CNT_LO: if (xfer) begin
                    cnt[7:0] <= s_dat;
                    state    <= CNT_HI;
                end
                CNT_HI: if (xfer) begin
                    cnt[15:8] <= s_dat;
                    if (cnt_nxt == 16'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_nxt > 16'(MAX_WORDS)) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= ERR;
                    end else begin
                        bidx  <= '0;
                        state <= DATA;
                    end
                end
                DATA: if (xfer) begin
                    asm_w <= word_nxt;
                    bidx  <= bidx + 1'b1;
                    if (bidx == BW'(BYTES - 1)) begin
                        // Enables/addr/data register here so they are
                        // valid exactly during the WRITE cycle.
                        if (sel_d) begin
                            d_w_enb  <= 1'b1;
                            d_w_addr <= addr_nxt;
                            d_w_dat  <= word_nxt;
                        end else begin
                            i_w_enb  <= 1'b1;
                            i_w_addr <= addr_nxt;
                            i_w_dat  <= word_nxt;
                        end
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    widx <= widx + 16'd1;
                    bidx <= '0;
                    if (widx + 16'd1 == cnt) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                    end
                end
                RUN: state <= RUN;
                ERR: state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_boot_loader.sv
// Directed testbench for bram_boot_loader: frames in, BRAM writes and
// control outputs checked against hand-computed values.
module tb_bram_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_dat;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  i_w_addr, d_w_addr;
    logic [31:0] i_w_dat, d_w_dat;
    logic        i_w_enb, d_w_enb;
    logic        pc_stall, d_bram_init_done, busy, error;

    int n_pass = 0;
    int n_total = 0;
    int spur = 0;

    typedef struct {
        logic        d;
        logic [9:0]  addr;
        logic [31:0] dat;
    } wr_t;
    wr_t wlog[$];

    always #5 clk = ~clk;

    bram_boot_loader dut (
        .clk(clk), .rst(rst),
        .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .pc_stall(pc_stall), .d_bram_init_done(d_bram_init_done),
        .busy(busy), .error(error)
    );

    // Write monitor: logs pulses, flags overlaps and multi-cycle pulses.
    logic prev_i = 1'b0, prev_d = 1'b0;
    always @(negedge clk) begin
        if (i_w_enb) wlog.push_back('{1'b0, i_w_addr, i_w_dat});
        if (d_w_enb) wlog.push_back('{1'b1, d_w_addr, d_w_dat});
        if (i_w_enb && d_w_enb) spur++;
        if ((i_w_enb && prev_i) || (d_w_enb && prev_d)) spur++;
        prev_i = i_w_enb;
        prev_d = d_w_enb;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n == 20) begin
            $display("FAIL send_byte timeout: s_ready=%b required 1", s_ready);
        end else begin
            n_pass++;
            s_dat   = b;
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        s_dat   = 8'h00;
        rst     = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        wlog.delete();
        spur = 0;
    endtask

    task automatic check_wr(input string nm, input int idx, input logic d,
                            input logic [9:0] a, input logic [31:0] v);
        n_total++;
        if (wlog.size() <= idx)
            $display("FAIL %s: write %0d missing, got %0d writes",
                     nm, idx, wlog.size());
        else if (wlog[idx].d !== d || wlog[idx].addr !== a ||
                 wlog[idx].dat !== v)
            $display("FAIL %s: got d=%b addr=%h dat=%h required d=%b addr=%h dat=%h",
                     nm, wlog[idx].d, wlog[idx].addr, wlog[idx].dat, d, a, v);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        s_dat = 8'hA5;
        #2;
        n_total++;
        if ({s_ready, pc_stall, busy, error, d_bram_init_done,
             i_w_enb, d_w_enb} !== 7'b0100000)
            $display("FAIL reset_ctrl: got %b required 0100000",
                     {s_ready, pc_stall, busy, error, d_bram_init_done,
                      i_w_enb, d_w_enb});
        else n_pass++;
        n_total++;
        if ({i_w_addr, d_w_addr, i_w_dat, d_w_dat} !== '0)
            $display("FAIL reset_bus: got %h required 0",
                     {i_w_addr, d_w_addr, i_w_dat, d_w_dat});
        else n_pass++;
        idle(2);
        s_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        n_total++;
        if (s_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_idle: s_ready=%b busy=%b required 1 0",
                     s_ready, busy);
        else n_pass++;
        wlog.delete();
        spur = 0;
    endtask

    task automatic test_instr_load();
        do_reset();
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                     8'h93, 8'h05, 8'h20, 8'h00});
        idle(2);
        n_total++;
        if (wlog.size() !== 2)
            $display("FAIL instr_count: got %0d writes required 2", wlog.size());
        else n_pass++;
        check_wr("instr_w0", 0, 1'b0, 10'h000, 32'h00100513);
        check_wr("instr_w1", 1, 1'b0, 10'h004, 32'h00200593);
        n_total++;
        if (pc_stall !== 1'b1 || busy !== 1'b0 || spur !== 0)
            $display("FAIL instr_ctrl: pc_stall=%b busy=%b spur=%0d required 1 0 0",
                     pc_stall, busy, spur);
        else n_pass++;
    endtask

    task automatic test_data_run();
        do_reset();
        send_frame('{8'h5A, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                     8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00});
        idle(2);
        check_wr("data_w0", 0, 1'b1, 10'h000, 32'h1);
        check_wr("data_w1", 1, 1'b1, 10'h004, 32'h3);
        check_wr("data_w2", 2, 1'b1, 10'h008, 32'h5);
        send_byte(8'hFF);
        n_total++;
        if ({pc_stall, d_bram_init_done, s_ready} !== 3'b010)
            $display("FAIL run: stall/init/ready=%b required 010",
                     {pc_stall, d_bram_init_done, s_ready});
        else n_pass++;
        s_dat = 8'hA5;
        s_valid = 1'b1;
        idle(4);
        s_valid = 1'b0;
        n_total++;
        if (busy !== 1'b0 || pc_stall !== 1'b0 || wlog.size() !== 3 || spur !== 0)
            $display("FAIL run_hold: busy=%b stall=%b writes=%0d spur=%0d required 0 0 3 0",
                     busy, pc_stall, wlog.size(), spur);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        do_reset();
        send_frame('{8'hA5, 8'h00, 8'h00});
        idle(1);
        n_total++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || wlog.size() !== 0)
            $display("FAIL zero_cnt: busy=%b ready=%b writes=%0d required 0 1 0",
                     busy, s_ready, wlog.size());
        else n_pass++;
        send_frame('{8'h5A, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        idle(2);
        n_total++;
        if (wlog.size() !== 1)
            $display("FAIL zero_next_count: got %0d writes required 1", wlog.size());
        else n_pass++;
        check_wr("zero_next_w0", 0, 1'b1, 10'h000, 32'hDEADBEEF);
    endtask

    task automatic test_errors();
        do_reset();
        send_frame('{8'hA5, 8'h00, 8'h01});
        n_total++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL max_cnt: error=%b busy=%b required 0 1", error, busy);
        else n_pass++;
        do_reset();
        send_frame('{8'hA5, 8'h01, 8'h01});
        n_total++;
        if ({error, s_ready, busy, pc_stall} !== 4'b1001 || wlog.size() !== 0)
            $display("FAIL over_cnt: err/ready/busy/stall=%b writes=%0d required 1001 0",
                     {error, s_ready, busy, pc_stall}, wlog.size());
        else n_pass++;
        do_reset();
        send_byte(8'h33);
        n_total++;
        if (error !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL bad_cmd: error=%b ready=%b required 1 0", error, s_ready);
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [7:0] pl[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        do_reset();
        send_frame('{8'h5A, 8'h01, 8'h00});
        foreach (pl[i]) begin
            send_byte(pl[i]);
            if (i < 3) idle(2);
        end
        idle(3);
        n_total++;
        if (wlog.size() !== 1 || spur !== 0)
            $display("FAIL gaps_count: writes=%0d spur=%0d required 1 0",
                     wlog.size(), spur);
        else n_pass++;
        check_wr("gaps_w0", 0, 1'b1, 10'h000, 32'h12345678);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05});
        rst = 1'b0;
        #2;
        n_total++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || pc_stall !== 1'b1)
            $display("FAIL mid_reset: ready=%b busy=%b stall=%b required 0 0 1",
                     s_ready, busy, pc_stall);
        else n_pass++;
        idle(2);
        rst = 1'b1;
        idle(2);
        n_total++;
        if (wlog.size() !== 0 || busy !== 1'b0 || pc_stall !== 1'b1)
            $display("FAIL mid_after: writes=%0d busy=%b stall=%b required 0 0 1",
                     wlog.size(), busy, pc_stall);
        else n_pass++;
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h80});
        idle(2);
        check_wr("mid_reload", 0, 1'b0, 10'h000, 32'h800002B7);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_dat = 8'h00;
        test_reset();
        test_instr_load();
        test_data_run();
        test_zero_count();
        test_errors();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
